elm_input_streamer: RTL

//  Parametrised front-end for the ELM inference engine. Requests test-vector beats from a

---
 rtl/elm_input_streamer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/elm_input_streamer.sv
// Purpose : requests DIN_W-bit beats from a source and assembles them into a VEC_W-bit feature vector.
// Latency : vec_valid rises BEATS+1 edges after start is sampled in IDLE; one vector per BEATS+2 cycles.
// Backpr. : vec_out/vec_valid held until vec_ready; no beats are requested while a vector waits.
// Option  : define ELM_INPUT_POPCNT_EN to add the popcnt output (ones count of vec_out).
module elm_input_streamer #(
   parameter  int VEC_W = 256,
   parameter  int DIN_W = 1,
   localparam int BEATS = VEC_W / DIN_W,
   localparam int CNT_W = $clog2(BEATS + 1),
   localparam int PC_W  = $clog2(VEC_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             din_valid,
   input  logic [DIN_W-1:0] din,
   output logic             give_input,
   output logic [VEC_W-1:0] vec_out,
   output logic             vec_valid,
   input  logic             vec_ready,
`ifdef ELM_INPUT_POPCNT_EN
   output logic [PC_W-1:0]  popcnt,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FILL = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [CNT_W-1:0]   req_cnt;
   logic [CNT_W-1:0]   smp_cnt;
   logic [VEC_W-1:0]   shreg;

   // Decoded actions for the current cycle
   logic               enter_req;   // (re)start a vector: clear counters and shift register
   logic               req_adv;     // one more request issued this cycle
   logic               load_vec;    // all beats sampled: publish the vector
   logic               release_vec; // consumer took the vector
   logic               smp_en;      // beat on din belongs to the vector being built

   // A beat is captured at the edge closing every cycle in which give_input was high;
   // the count guard keeps smp_cnt from wrapping.
   assign smp_en = give_input && (smp_cnt != CNT_W'(BEATS));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and action decode; dropping start aborts anything not yet published
   always_comb begin
      state_nxt   = state;
      enter_req   = 1'b0;
      req_adv     = 1'b0;
      load_vec    = 1'b0;
      release_vec = 1'b0;
      case (state)
         IDLE: begin
            if (start && din_valid) begin
               state_nxt = REQ;
               enter_req = 1'b1;
            end
         end
         REQ: begin
            if (!start) begin
               state_nxt = IDLE;
            end else begin
               req_adv = 1'b1;
               // req_cnt counts requests already completed; this cycle carries the last one
               if (req_cnt == CNT_W'(BEATS - 1)) begin
                  state_nxt = FILL;
               end
            end
         end
         FILL: begin
            if (!start) begin
               state_nxt = IDLE;
            end else if (smp_cnt == CNT_W'(BEATS)) begin
               state_nxt = HOLD;
               load_vec  = 1'b1;
            end
         end
         HOLD: begin
            // start is deliberately ignored here: a completed vector is always delivered
            if (vec_valid && vec_ready) begin
               release_vec = 1'b1;
               if (start && din_valid) begin
                  state_nxt = REQ;
                  enter_req = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered control outputs follow the state being entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         give_input <= 1'b0;
         busy       <= 1'b0;
      end else begin
         give_input <= (state_nxt == REQ);
         busy       <= (state_nxt != IDLE);
      end
   end

   // Request counter, saturating at BEATS
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_cnt <= '0;
      end else if (enter_req) begin
         req_cnt <= '0;
      end else if (req_adv && (req_cnt != CNT_W'(BEATS))) begin
         req_cnt <= req_cnt + 1'b1;
      end
   end

   // Deserialiser: first beat ends up in the MSBs after BEATS shifts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         smp_cnt <= '0;
      end else if (enter_req) begin
         shreg   <= '0;
         smp_cnt <= '0;
      end else if (smp_en) begin
         shreg   <= {shreg[VEC_W-DIN_W-1:0], din};
         smp_cnt <= smp_cnt + 1'b1;
      end
   end

   // Output vector register; vec_out keeps its last value once released
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vec_out   <= '0;
         vec_valid <= 1'b0;
      end else if (load_vec) begin
         vec_out   <= shreg;
         vec_valid <= 1'b1;
      end else if (release_vec) begin
         vec_valid <= 1'b0;
      end
   end

`ifdef ELM_INPUT_POPCNT_EN
   logic [PC_W-1:0] beat_ones;
   logic [PC_W-1:0] pop_acc;

   // Ones in the beat currently on din
   always_comb begin
      beat_ones = '0;
      for (int i = 0; i < DIN_W; i++) begin
         beat_ones = beat_ones + PC_W'(din[i]);
      end
   end

   // Running ones count tracks the shift register and is published with vec_out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pop_acc <= '0;
         popcnt  <= '0;
      end else begin
         if (enter_req) begin
            pop_acc <= '0;
         end else if (smp_en) begin
            pop_acc <= pop_acc + beat_ones;
         end
         if (load_vec) begin
            popcnt <= pop_acc;
         end
      end
   end
`endif

endmodule
